// File: rtl/sync_wedge_multi.sv
// sync_wedge_multi: NUM_CH-channel input conditioner.
// Each channel runs a STAGES-deep synchroniser, then a DEBOUNCE-cycle stability
// filter, then a registered rise/fall edge detector. Edges that match the
// per-channel mode set sticky pending flags, and those flags OR into irq_o.
// Optional feature macro: SYNC_WEDGE_MULTI_EVT_CNT_EN adds one saturating
// event counter per channel, exposed on evt_cnt_o.
module sync_wedge_multi #(
   parameter int NUM_CH   = 8,
   parameter int STAGES   = 2,
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic [NUM_CH-1:0]       serial_i,
   input  logic [2*NUM_CH-1:0]     mode_i,
   input  logic [NUM_CH-1:0]       pend_clr_i,
   output logic [NUM_CH-1:0]       serial_o,
   output logic [NUM_CH-1:0]       r_edge_o,
   output logic [NUM_CH-1:0]       f_edge_o,
   output logic [NUM_CH-1:0]       pend_o,
   output logic                    irq_o
`ifdef SYNC_WEDGE_MULTI_EVT_CNT_EN
   ,output logic [CNT_W*NUM_CH-1:0] evt_cnt_o
`endif
);

   // A debounce counter is always at least one bit wide, so DEBOUNCE=1 still elaborates.
   localparam int              DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);
   localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

   logic [STAGES-1:0][NUM_CH-1:0] r_sync;
   logic [NUM_CH-1:0][DB_W-1:0]   r_cnt;
   logic [NUM_CH-1:0]             r_level;
   logic [NUM_CH-1:0]             r_rise;
   logic [NUM_CH-1:0]             r_fall;
   logic [NUM_CH-1:0]             r_pend;
   logic [NUM_CH-1:0]             w_sync;
   logic [NUM_CH-1:0]             w_qual;

   assign w_sync   = r_sync[STAGES-1];
   assign serial_o = r_level;
   assign r_edge_o = r_rise;
   assign f_edge_o = r_fall;
   assign pend_o   = r_pend;
   assign irq_o    = |r_pend;

   // Synchroniser chain. It is free-running and ignores en_i, so it is always settled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync <= '0;
      end else if (clr_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], serial_i};
      end
   end

   // Stability filter and edge detector. A new level is accepted, and the edge
   // pulse is raised, on the same clock edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt   <= '0;
         r_level <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
      end else if (clr_i) begin
         r_cnt   <= '0;
         r_level <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
      end else if (en_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_rise[i] <= 1'b0;
            r_fall[i] <= 1'b0;
            if (w_sync[i] == r_level[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DB_MAX) begin
               r_level[i] <= w_sync[i];
               r_cnt[i]   <= '0;
               r_rise[i]  <= w_sync[i];
               r_fall[i]  <= ~w_sync[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + DB_ONE;
            end
         end
      end else begin
         r_rise <= '0;
         r_fall <= '0;
      end
   end

   // An edge is qualified when its type is enabled in the channel's current mode bits.
   always_comb begin
      w_qual = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_qual[i] = (r_rise[i] & mode_i[2*i]) | (r_fall[i] & mode_i[2*i+1]);
      end
   end

   // Sticky pending flags. When a set and a clear land in the same cycle, the set wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pend <= '0;
      end else if (clr_i) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~pend_clr_i) | w_qual;
      end
   end

`ifdef SYNC_WEDGE_MULTI_EVT_CNT_EN
   logic [NUM_CH-1:0][CNT_W-1:0] r_evt;
   localparam logic [CNT_W-1:0] EVT_ONE = CNT_W'(1);

   assign evt_cnt_o = r_evt;

   // Saturating per-channel count of qualified edges. pend_clr_i does not touch it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_evt <= '0;
      end else if (clr_i) begin
         r_evt <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_qual[i] && (r_evt[i] != {CNT_W{1'b1}})) begin
               r_evt[i] <= r_evt[i] + EVT_ONE;
            end else begin
               r_evt[i] <= r_evt[i];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_wedge_multi.sv
// Directed self-checking bench for sync_wedge_multi (NUM_CH=8, STAGES=2, DEBOUNCE=4).
module tb_sync_wedge_multi;

   localparam int NUM_CH = 8;
`ifdef SYNC_WEDGE_MULTI_EVT_CNT_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 8;
`endif

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic                  clr_i;
   logic                  en_i;
   logic [NUM_CH-1:0]     serial_i;
   logic [2*NUM_CH-1:0]   mode_i;
   logic [NUM_CH-1:0]     pend_clr_i;
   logic [NUM_CH-1:0]     serial_o;
   logic [NUM_CH-1:0]     r_edge_o;
   logic [NUM_CH-1:0]     f_edge_o;
   logic [NUM_CH-1:0]     pend_o;
   logic                  irq_o;
`ifdef SYNC_WEDGE_MULTI_EVT_CNT_EN
   logic [CNT_W*NUM_CH-1:0] evt_cnt_o;
`endif

   int n_chk = 0;
   int n_err = 0;

   sync_wedge_multi #(.NUM_CH(NUM_CH), .STAGES(2), .DEBOUNCE(4), .CNT_W(CNT_W)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (clr_i),
      .en_i       (en_i),
      .serial_i   (serial_i),
      .mode_i     (mode_i),
      .pend_clr_i (pend_clr_i),
      .serial_o   (serial_o),
      .r_edge_o   (r_edge_o),
      .f_edge_o   (f_edge_o),
      .pend_o     (pend_o),
      .irq_o      (irq_o)
`ifdef SYNC_WEDGE_MULTI_EVT_CNT_EN
      ,.evt_cnt_o (evt_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // One record: drive channel ch to lvl (optionally only for `pulse` cycles), then
   // watch ncyc cycles. acc = cycle of acceptance (99 = never). p0/p1 = pend before/after.
   typedef struct {
      int   ch;
      logic lvl;
      int   pulse;
      int   acc;
      logic p0;
      logic p1;
      int   ncyc;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic old;
      // mode: ch0=01 rise, ch1=01 rise, ch2=10 fall, ch3=11 both, ch4..7=00 none
      tbl[0] = '{0, 1'b1, 0, 6,  1'b0, 1'b1, 8};   // latency, rise qualified
      tbl[1] = '{1, 1'b1, 3, 99, 1'b0, 1'b0, 10};  // 3-cycle glitch rejected
      tbl[2] = '{1, 1'b1, 0, 6,  1'b0, 1'b1, 8};   // steady high accepted
      tbl[3] = '{2, 1'b1, 0, 6,  1'b0, 1'b0, 8};   // fall mode ignores rise
      tbl[4] = '{2, 1'b0, 0, 6,  1'b0, 1'b1, 8};   // fall mode takes fall
      tbl[5] = '{3, 1'b1, 0, 6,  1'b0, 1'b1, 8};   // both mode: rise
      tbl[6] = '{3, 1'b0, 0, 6,  1'b1, 1'b1, 8};   // both mode: stays set
      tbl[7] = '{4, 1'b1, 0, 6,  1'b0, 1'b0, 8};   // mode none: edge, no pend
      tbl[8] = '{4, 1'b0, 2, 99, 1'b0, 1'b0, 10};  // falling glitch rejected
      tbl[9] = '{0, 1'b0, 0, 6,  1'b1, 1'b1, 8};   // rise mode ignores fall

      rst_ni = 1'b0; clr_i = 1'b0; en_i = 1'b1;
      serial_i = 8'h00; mode_i = 16'h00E5; pend_clr_i = 8'h00;
      #12;
      check("rst_serial", serial_o, 32'h0);
      check("rst_redge",  r_edge_o, 32'h0);
      check("rst_fedge",  f_edge_o, 32'h0);
      check("rst_pend",   pend_o,   32'h0);
      check("rst_irq",    irq_o,    32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      // Table-driven channel sequences
      for (int r = 0; r < 10; r++) begin
         old = ~tbl[r].lvl;
         serial_i[tbl[r].ch] = tbl[r].lvl;
         for (int k = 1; k <= tbl[r].ncyc; k++) begin
            tick();
            if (tbl[r].pulse > 0 && k == tbl[r].pulse) serial_i[tbl[r].ch] = old;
            check($sformatf("v%0d_serial_k%0d", r, k), serial_o[tbl[r].ch],
                  (k >= tbl[r].acc) ? tbl[r].lvl : old);
            check($sformatf("v%0d_redge_k%0d", r, k), r_edge_o[tbl[r].ch],
                  tbl[r].lvl && (k == tbl[r].acc));
            check($sformatf("v%0d_fedge_k%0d", r, k), f_edge_o[tbl[r].ch],
                  !tbl[r].lvl && (k == tbl[r].acc));
            check($sformatf("v%0d_pend_k%0d", r, k), pend_o[tbl[r].ch],
                  (k >= tbl[r].acc + 1) ? tbl[r].p1 : tbl[r].p0);
         end
      end
      check("pend_after_table", pend_o, 32'h0F);
      check("irq_after_table",  irq_o,  32'h1);

      // Clear race on ch3: a set and a clear in the same cycle leave the flag set
      pend_clr_i = 8'hF7;
      tick();
      pend_clr_i = 8'h00;
      check("race_pre_pend", pend_o, 32'h08);
      check("race_pre_irq",  irq_o,  32'h1);
      serial_i[3] = 1'b1;
      for (int k = 1; k <= 6; k++) tick();
      check("race_redge3", r_edge_o[3], 32'h1);
      pend_clr_i = 8'h08;
      tick();
      check("race_pend3_kept", pend_o[3], 32'h1);
      tick();
      pend_clr_i = 8'h00;
      check("race_pend_clr", pend_o, 32'h0);
      check("race_irq_clr",  irq_o,  32'h0);

      // With enable low, the input change must not propagate to serial_o
      en_i = 1'b0;
      serial_i[5] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("en0_serial5_k%0d", k), serial_o[5], 32'h0);
         check($sformatf("en0_redge_k%0d", k),   r_edge_o,    32'h0);
      end
      en_i = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("en1_serial5_k%0d", k), serial_o[5], (k >= 4) ? 32'h1 : 32'h0);
         check($sformatf("en1_redge5_k%0d", k),  r_edge_o[5], (k == 4) ? 32'h1 : 32'h0);
      end

      // clr_i while ch6 is mid-debounce
      serial_i[6] = 1'b1;
      for (int k = 1; k <= 4; k++) tick();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("clr_serial", serial_o, 32'h0);
      check("clr_redge",  r_edge_o, 32'h0);
      check("clr_fedge",  f_edge_o, 32'h0);
      check("clr_pend",   pend_o,   32'h0);
      check("clr_irq",    irq_o,    32'h0);
      // serial_i = 0x7A is still applied, so the full latency starts again from the clear
      for (int k = 1; k <= 7; k++) begin
         tick();
         check($sformatf("reacq_serial_k%0d", k), serial_o, (k >= 6) ? 32'h7A : 32'h0);
         check($sformatf("reacq_redge_k%0d", k),  r_edge_o, (k == 6) ? 32'h7A : 32'h0);
         check($sformatf("reacq_pend_k%0d", k),   pend_o,   (k >= 7) ? 32'h0A : 32'h0);
      end

`ifdef SYNC_WEDGE_MULTI_EVT_CNT_EN
      check("evt_ch1_one", evt_cnt_o[3:2], 32'h1);
      for (int n = 1; n <= 5; n++) begin
         serial_i[0] = 1'b1;
         for (int k = 1; k <= 8; k++) tick();
         check($sformatf("evt_ch0_rise%0d", n), evt_cnt_o[1:0], (n > 3) ? 32'h3 : n);
         serial_i[0] = 1'b0;
         for (int k = 1; k <= 8; k++) tick();
      end
      check("evt_ch0_after_falls", evt_cnt_o[1:0], 32'h3);
      pend_clr_i = 8'hFF;
      tick();
      pend_clr_i = 8'h00;
      check("evt_ch0_pendclr", evt_cnt_o[1:0], 32'h3);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("evt_clr", evt_cnt_o, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
